// File: rtl/hnf_txreq_arb_pkg.sv
// Shared CHI request-channel types and constants for the HN-F TXREQ path.
package hnf_txreq_arb_pkg;

  // Largest number of L-credits a CHI receiver may hand out on one channel.
  localparam int unsigned CHI_MAX_LCRD = 15;

  typedef struct packed {
    logic [3:0]  qos;
    logic [6:0]  tgt_id;
    logic [6:0]  src_id;
    logic [7:0]  txn_id;
    logic [5:0]  opcode;
    logic [31:0] addr;
  } reqflit_t;

  // (base + offset) mod n, assuming base < n and offset < n.
  function automatic int unsigned rr_index(int unsigned base, int unsigned offset,
                                           int unsigned n);
    int unsigned sum;
    sum = base + offset;
    return (sum >= n) ? sum - n : sum;
  endfunction

endpackage

// File: rtl/hnf_rr_arb.sv
// Round-robin arbiter: the pointer names the highest-priority requester and moves to
// one past the winner whenever the caller reports that the grant was taken.
module hnf_rr_arb
  import hnf_txreq_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  localparam int unsigned IdxW = $clog2(NUM_REQ)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [IdxW-1:0]    winner
);

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] idx;
  logic            found;

  // Search req starting at ptr, wrapping modulo NUM_REQ; first hit wins.
  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = IdxW'(rr_index(32'(ptr_q), off, NUM_REQ));
      if (enable && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        winner     = idx;
      end
    end
  end

  // Pointer moves past the winner only on a taken grant.
  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (winner == IdxW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    end
  end

  // Pointer register.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/hnf_txreq_arb.sv
// HN-F TXREQ link arbiter: owns the TXREQ L-credit counter, picks one internal requester
// per cycle round-robin, and registers the winning flit onto the link.
module hnf_txreq_arb
  import hnf_txreq_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned MAX_CRD = CHI_MAX_LCRD,
  localparam int unsigned CrdW = $clog2(MAX_CRD + 1),
  localparam int unsigned IdxW = $clog2(NUM_REQ)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  reqflit_t [NUM_REQ-1:0]   req_flit,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  output reqflit_t                 TXREQFLIT,
  output logic                     TXREQFLITV,
  output logic                     TXREQFLITPEND,
  input  logic                     TXREQLCRDV,
  output logic [CrdW-1:0]          crd_cnt,
  output logic                     crd_ovf
);

  localparam logic [CrdW-1:0] CrdMax = CrdW'(MAX_CRD);

  logic [CrdW-1:0] crd_q, crd_d;
  logic            ovf_q, ovf_d;
  reqflit_t        flit_q, flit_d;
  logic            flitv_q;
  logic            accept;
  logic [IdxW-1:0] winner;

  // Credits are only usable the cycle after they arrive, so the enable uses the register.
  hnf_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arb (
    .clock   (clock),
    .reset   (reset),
    .req     (req_valid),
    .enable  (crd_q != '0),
    .advance (accept),
    .grant   (req_ready),
    .winner  (winner)
  );

  // Grants are already qualified by valid, so any grant is an accept.
  always_comb begin
    accept        = |(req_valid & req_ready);
    TXREQFLITPEND = accept;
  end

  // Credit counter: +1 on LCRDV, -1 on accept, saturate and flag overflow at the top.
  always_comb begin
    crd_d = crd_q;
    ovf_d = ovf_q;
    if (TXREQLCRDV && !accept) begin
      if (crd_q == CrdMax) begin
        ovf_d = 1'b1;
      end else begin
        crd_d = crd_q + 1'b1;
      end
    end else if (!TXREQLCRDV && accept) begin
      crd_d = crd_q - 1'b1;
    end
  end

  // Output flit holds its last value when nothing is sent.
  always_comb begin
    flit_d = flit_q;
    if (accept) begin
      flit_d = req_flit[winner];
    end
  end

  // State registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      crd_q   <= '0;
      ovf_q   <= 1'b0;
      flit_q  <= '0;
      flitv_q <= 1'b0;
    end else begin
      crd_q   <= crd_d;
      ovf_q   <= ovf_d;
      flit_q  <= flit_d;
      flitv_q <= accept;
    end
  end

  // Output wiring.
  always_comb begin
    TXREQFLIT  = flit_q;
    TXREQFLITV = flitv_q;
    crd_cnt    = crd_q;
    crd_ovf    = ovf_q;
  end

endmodule

// File: tb/tb_hnf_txreq_arb.sv
// Bench for hnf_txreq_arb: a directed vector table, hand-written corner sequences and a
// randomized run, all compared against a cycle-level reference model of the link rules.
module tb_hnf_txreq_arb;
  import hnf_txreq_arb_pkg::*;

  localparam int N = 3;
  localparam int MAXC = 15;

  logic               clock = 1'b0;
  logic               reset;
  reqflit_t [N-1:0]   req_flit;
  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_ready;
  reqflit_t           TXREQFLIT;
  logic               TXREQFLITV;
  logic               TXREQFLITPEND;
  logic               TXREQLCRDV;
  logic [3:0]         crd_cnt;
  logic               crd_ovf;

  hnf_txreq_arb dut (
    .clock         (clock),
    .reset         (reset),
    .req_flit      (req_flit),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .TXREQFLIT     (TXREQFLIT),
    .TXREQFLITV    (TXREQFLITV),
    .TXREQFLITPEND (TXREQFLITPEND),
    .TXREQLCRDV    (TXREQLCRDV),
    .crd_cnt       (crd_cnt),
    .crd_ovf       (crd_ovf)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  // Reference model state.
  int       m_crd;
  int       m_ptr;
  logic     m_ovf;
  logic     m_flitv;
  reqflit_t m_flit;

  // Requester side: pending valids and per-requester transaction counters.
  logic [N-1:0] vld;
  int           txn [N];

  typedef struct {
    logic [2:0] v;
    logic       l;
    logic [2:0] rdy;
    logic       pend;
    logic       flitv;
    int         fidx;
    logic [3:0] crd;
  } vec_t;

  vec_t tbl [20];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic reqflit_t make_flit(int i, int t);
    reqflit_t f;
    f.qos    = 4'(i);
    f.tgt_id = 7'h20;
    f.src_id = 7'(i + 1);
    f.txn_id = 8'(t);
    f.opcode = 6'h04;
    f.addr   = 32'(t * 256 + i);
    return f;
  endfunction

  task automatic drive(input logic l);
    req_valid  = vld;
    TXREQLCRDV = l;
    for (int i = 0; i < N; i++) req_flit[i] = make_flit(i, txn[i]);
  endtask

  // One cycle: drive, check against the model, then advance the model.
  task automatic step(input logic l);
    int w;
    logic [N-1:0] exp_rdy;
    @(negedge clock);
    drive(l);
    #1;
    w = -1;
    if (m_crd != 0) begin
      for (int k = 0; k < N; k++) begin
        if (w < 0 && vld[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      end
    end
    exp_rdy = '0;
    if (w >= 0) exp_rdy[w] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("pend", 64'(TXREQFLITPEND), 64'(w >= 0));
    chk("flitv", 64'(TXREQFLITV), 64'(m_flitv));
    chk("crd_cnt", 64'(crd_cnt), 64'(m_crd));
    chk("crd_ovf", 64'(crd_ovf), 64'(m_ovf));
    if (m_flitv) chk("flit", 64'(TXREQFLIT), 64'(m_flit));
    if (l && w < 0) begin
      if (m_crd == MAXC) m_ovf = 1'b1;
      else m_crd++;
    end else if (!l && w >= 0) begin
      m_crd--;
    end
    m_flitv = (w >= 0);
    if (w >= 0) begin
      m_ptr  = (w + 1) % N;
      m_flit = make_flit(w, txn[w]);
      txn[w]++;
      vld[w] = 1'b0;
    end
  endtask

  // Synchronous reset for one cycle, then check the reset state.
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    vld   = '0;
    drive(1'b0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_ready", 64'(req_ready), 64'(0));
    chk("rst_pend", 64'(TXREQFLITPEND), 64'(0));
    chk("rst_flitv", 64'(TXREQFLITV), 64'(0));
    chk("rst_flit", 64'(TXREQFLIT), 64'(0));
    chk("rst_crd", 64'(crd_cnt), 64'(0));
    chk("rst_ovf", 64'(crd_ovf), 64'(0));
    m_crd = 0; m_ptr = 0; m_ovf = 1'b0; m_flitv = 1'b0; m_flit = '0;
  endtask

  initial begin
    int pl [4];
    int pv [4];
    reset = 1'b1;
    vld = '0;
    for (int i = 0; i < N; i++) txn[i] = 0;
    drive(1'b0);

    // Vector table: credit starvation, then 4 credits drained by 0,1,2,0.
    for (int i = 0; i < 10; i++) tbl[i] = '{3'b111, 1'b0, 3'b000, 1'b0, 1'b0, 0, 4'd0};
    tbl[10] = '{3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 0, 4'd0};
    tbl[11] = '{3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 0, 4'd1};
    tbl[12] = '{3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 0, 4'd2};
    tbl[13] = '{3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 0, 4'd3};
    tbl[14] = '{3'b111, 1'b0, 3'b001, 1'b1, 1'b0, 0, 4'd4};
    tbl[15] = '{3'b111, 1'b0, 3'b010, 1'b1, 1'b1, 0, 4'd3};
    tbl[16] = '{3'b111, 1'b0, 3'b100, 1'b1, 1'b1, 1, 4'd2};
    tbl[17] = '{3'b111, 1'b0, 3'b001, 1'b1, 1'b1, 2, 4'd1};
    tbl[18] = '{3'b111, 1'b0, 3'b000, 1'b0, 1'b1, 0, 4'd0};
    tbl[19] = '{3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 0, 4'd0};

    do_reset();
    for (int r = 0; r < 20; r++) begin
      @(negedge clock);
      req_valid  = tbl[r].v;
      TXREQLCRDV = tbl[r].l;
      for (int i = 0; i < N; i++) req_flit[i] = make_flit(i, 0);
      #1;
      chk($sformatf("tbl%0d_ready", r), 64'(req_ready), 64'(tbl[r].rdy));
      chk($sformatf("tbl%0d_pend", r), 64'(TXREQFLITPEND), 64'(tbl[r].pend));
      chk($sformatf("tbl%0d_flitv", r), 64'(TXREQFLITV), 64'(tbl[r].flitv));
      chk($sformatf("tbl%0d_crd", r), 64'(crd_cnt), 64'(tbl[r].crd));
      if (tbl[r].flitv) begin
        chk($sformatf("tbl%0d_flit", r), 64'(TXREQFLIT), 64'(make_flit(tbl[r].fidx, 0)));
      end
    end

    // Credit every cycle, only requester 2: one flit per cycle, counter parked at 1.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      vld[2] = 1'b1;
      step(1'b1);
    end
    chk("stream_crd", 64'(crd_cnt), 64'(1));
    vld = '0;
    step(1'b0);

    // Overflow: 16 credits with no requests; sticky until reset.
    do_reset();
    for (int c = 0; c < 16; c++) step(1'b1);
    chk("ovf_pre_crd", 64'(crd_cnt), 64'(15));
    chk("ovf_pre_flag", 64'(crd_ovf), 64'(0));
    step(1'b0);
    chk("ovf_flag", 64'(crd_ovf), 64'(1));
    for (int c = 0; c < 5; c++) step(1'b0);
    chk("ovf_sticky", 64'(crd_ovf), 64'(1));

    // Full counter: credit and accept together keep 15 with no overflow.
    do_reset();
    for (int c = 0; c < 15; c++) step(1'b1);
    vld[0] = 1'b1;
    step(1'b1);
    step(1'b0);
    chk("full_crd", 64'(crd_cnt), 64'(15));
    chk("full_ovf", 64'(crd_ovf), 64'(0));

    // Reset with credits held and a flit on the link; arbitration restarts at index 0.
    do_reset();
    for (int c = 0; c < 5; c++) step(1'b1);
    for (int c = 0; c < 2; c++) begin
      vld = 3'b111;
      step(1'b0);
    end
    vld = '0;
    step(1'b0);
    chk("mid_crd", 64'(crd_cnt), 64'(3));
    do_reset();
    step(1'b1);
    vld = 3'b111;
    step(1'b0);
    chk("mid_ptr0", 64'(req_ready), 64'(1));

    // Randomized phases with varying credit and request pressure.
    do_reset();
    vld = '0;
    pl = '{90, 30, 50, 100};
    pv = '{10, 80, 50, 60};
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 150; c++) begin
        for (int i = 0; i < N; i++) begin
          if (!vld[i] && $urandom_range(0, 99) < pv[p]) vld[i] = 1'b1;
        end
        step($urandom_range(0, 99) < pl[p]);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
